// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the debounced pushbutton reader.
// The board clock rate sets the default debounce and long-press times.

package button_pkg;

   localparam int CLK_HZ        = 12000000;
   localparam int PRESS_COUNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      LONG_HELD,
      DEB_RELEASE
   } btn_state_t;

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchroniser for one asynchronous input bit.
// Both flops reset to RESET_VAL, so an idle pin reads as its inactive level.

module btn_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the raw pin into the clk domain.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make meta and q behave as a real
      // two-flop chain; blocking ones would collapse it to a single flop.
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_reader.sv
// button_reader: synchronises and debounces an active-low pushbutton,
// producing a clean level, one-cycle press/release/long-press pulses and a
// wrapping press counter. All outputs are registered.
// Optional feature macro: BUTTON_READER_LONG_PRESS_EN enables the long-press
// detector (LONG_HELD state, lcnt, long_done); without it long_pulse is 0.

module button_reader
   import button_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = CLK_HZ / 100,
   parameter int LONG_TICKS     = CLK_HZ
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     btn_n,
   output logic                     pressed,
   output logic                     press_pulse,
   output logic                     release_pulse,
   output logic                     long_pulse,
   output logic [PRESS_COUNT_W-1:0] press_count
);

   localparam int            DW        = $clog2(DEBOUNCE_TICKS);
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_TICKS - 1);

   btn_state_t               state, state_nx;
   logic [DW-1:0]            dcnt, dcnt_nx;
   logic                     pressed_nx, press_pulse_nx, release_pulse_nx;
   logic [PRESS_COUNT_W-1:0] press_count_nx;
   logic                     btn_sync_n;
   logic                     s;

`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam int            LW        = $clog2(LONG_TICKS);
   localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_TICKS - 1);

   logic [LW-1:0] lcnt, lcnt_nx;
   logic          long_done, long_done_nx;
   logic          long_pulse_nx;
`endif

   // Tick counts below 2 are illegal; this block elaborates to no hardware.
   if (DEBOUNCE_TICKS < 2 || LONG_TICKS < 2) begin : g_bad_tick_params
   end

   btn_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_n),
      .q   (btn_sync_n)
   );

   // s is 1 while the synchronised pin is low (button pressed).
   assign s = ~btn_sync_n;

   // Next-state and next-output logic of the debounce FSM.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_nx         = state;
      dcnt_nx          = dcnt;
      pressed_nx       = pressed;
      press_pulse_nx   = 1'b0;
      release_pulse_nx = 1'b0;
      press_count_nx   = press_count;
`ifdef BUTTON_READER_LONG_PRESS_EN
      lcnt_nx          = lcnt;
      long_done_nx     = long_done;
      long_pulse_nx    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (s) begin
               state_nx = DEB_PRESS;
               dcnt_nx  = '0;
            end
         end
         DEB_PRESS: begin
            if (!s) begin
               state_nx = IDLE;
            end else if (dcnt == DCNT_LAST) begin
               state_nx       = HELD;
               pressed_nx     = 1'b1;
               press_pulse_nx = 1'b1;
               press_count_nx = press_count + 1'b1;
`ifdef BUTTON_READER_LONG_PRESS_EN
               lcnt_nx        = '0;
`endif
            end else begin
               dcnt_nx = dcnt + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_nx = DEB_RELEASE;
               dcnt_nx  = '0;
`ifdef BUTTON_READER_LONG_PRESS_EN
            end else if (lcnt == LCNT_LAST) begin
               state_nx      = LONG_HELD;
               long_pulse_nx = 1'b1;
               long_done_nx  = 1'b1;
            end else begin
               lcnt_nx = lcnt + 1'b1;
`endif
            end
         end
`ifdef BUTTON_READER_LONG_PRESS_EN
         LONG_HELD: begin
            if (!s) begin
               state_nx = DEB_RELEASE;
               dcnt_nx  = '0;
            end
         end
`endif
         DEB_RELEASE: begin
            if (s) begin
               // Release bounce: resume where the press left off; lcnt is
               // untouched so the long press is neither retriggered nor delayed.
`ifdef BUTTON_READER_LONG_PRESS_EN
               state_nx = long_done ? LONG_HELD : HELD;
`else
               state_nx = HELD;
`endif
            end else if (dcnt == DCNT_LAST) begin
               state_nx         = IDLE;
               pressed_nx       = 1'b0;
               release_pulse_nx = 1'b1;
`ifdef BUTTON_READER_LONG_PRESS_EN
               long_done_nx     = 1'b0;
`endif
            end else begin
               dcnt_nx = dcnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, counter and registered-output update; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         dcnt          <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         press_count   <= '0;
      end else begin
         state         <= state_nx;
         dcnt          <= dcnt_nx;
         pressed       <= pressed_nx;
         press_pulse   <= press_pulse_nx;
         release_pulse <= release_pulse_nx;
         press_count   <= press_count_nx;
      end
   end

`ifdef BUTTON_READER_LONG_PRESS_EN
   // Long-press counter, flag and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lcnt       <= '0;
         long_done  <= 1'b0;
         long_pulse <= 1'b0;
      end else begin
         lcnt       <= lcnt_nx;
         long_done  <= long_done_nx;
         long_pulse <= long_pulse_nx;
      end
   end
`else
   assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed self-checking bench for button_reader with
// DEBOUNCE_TICKS=4 and LONG_TICKS=16. Expectations follow the
// BUTTON_READER_LONG_PRESS_EN macro when it is defined for the build.

module tb_button_reader;

   localparam int DEB  = 4;
   localparam int LONG = 16;

`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_n;
   logic       pressed;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   int n_checks = 0;
   int n_fail   = 0;
   int multi_err = 0;

   typedef struct {
      logic       btn_n;
      logic       rst;
      logic       exp_pressed;
      logic       exp_press;
      logic       exp_release;
      logic       exp_long;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   button_reader #(
      .DEBOUNCE_TICKS (DEB),
      .LONG_TICKS     (LONG)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .press_count   (press_count)
   );

   always #5 clk = ~clk;

   // At most one event pulse may be high in any cycle.
   always @(negedge clk) begin
      if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1)
         multi_err++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 2 ms");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic b, input logic r, input logic p,
                               input logic pp, input logic rp, input logic lp,
                               input logic [7:0] c);
      vec_t v;
      v.btn_n = b; v.rst = r; v.exp_pressed = p; v.exp_press = pp;
      v.exp_release = rp; v.exp_long = lp; v.exp_count = c;
      vecs.push_back(v);
   endfunction

   function automatic int pack_out(input logic p, input logic pp, input logic rp,
                                   input logic lp, input logic [7:0] c);
      return int'({p, pp, rp, lp, c});
   endfunction

   // One clock step: inputs are already driven; sample after the rising edge.
   task automatic step();
      @(negedge clk);
   endtask

   int pp_at, pp_n, rel_at, rel_n, long_at, long_n, pp_total, rel_total;

   initial begin
      // ---------------- vector table ----------------
      for (int j = 0; j < 2; j++) add(1'b1, 1'b1, 0, 0, 0, 0, 8'd0);   // reset
      for (int j = 0; j < 3; j++) add(1'b1, 1'b0, 0, 0, 0, 0, 8'd0);   // idle
      for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 0, 0, 0, 0, 8'd0);   // glitch low
      for (int j = 0; j < 10; j++) add(1'b1, 1'b0, 0, 0, 0, 0, 8'd0);  // glitch ends
      for (int j = 0; j < 30; j++)                                     // clean press
         add(1'b0, 1'b0, j >= 6, j == 6, 1'b0, LONG_EN && (j == 22),
             (j >= 6) ? 8'd1 : 8'd0);
      for (int j = 0; j < 12; j++)                                     // clean release
         add(1'b1, 1'b0, j < 6, 1'b0, j == 6, 1'b0, 8'd1);

      rst   = 1'b1;
      btn_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         btn_n = vecs[i].btn_n;
         rst   = vecs[i].rst;
         step();
         check($sformatf("vec[%0d] {pressed,press,release,long,count}", i),
               pack_out(pressed, press_pulse, release_pulse, long_pulse, press_count),
               pack_out(vecs[i].exp_pressed, vecs[i].exp_press, vecs[i].exp_release,
                        vecs[i].exp_long, vecs[i].exp_count));
      end

      // ---------------- long hold (40 cycles) ----------------
      pp_at = -1; long_at = -1; long_n = 0;
      btn_n = 1'b0;
      for (int j = 0; j < 40; j++) begin
         step();
         if (press_pulse && pp_at < 0) pp_at = j;
         if (long_pulse) begin long_n++; long_at = j; end
      end
      check("hold press_pulse edge", pp_at, 6);
      check("hold long_pulse count", long_n, LONG_EN ? 1 : 0);
      check("hold long_pulse edge", long_at, LONG_EN ? 6 + LONG : -1);
      check("hold press_count", press_count, 2);

      // ---------------- release with 2-cycle high-low bounce ----------------
      rel_at = -1; rel_n = 0; long_n = 0;
      for (int j = 0; j < 18; j++) begin
         btn_n = (j < 2 || j >= 4);
         step();
         if (release_pulse) begin rel_n++; rel_at = j; end
         if (long_pulse) long_n++;
      end
      check("bounce release_pulse count", rel_n, 1);
      check("bounce release_pulse edge", rel_at, 10);
      check("bounce no second long_pulse", long_n, 0);
      check("bounce pressed after release", pressed, 0);

      // ---------------- reset mid-press ----------------
      btn_n = 1'b0;
      repeat (10) step();
      check("pre-reset pressed", pressed, 1);
      rst = 1'b1;
      step();
      check("reset outputs cleared",
            pack_out(pressed, press_pulse, release_pulse, long_pulse, press_count), 0);
      rst = 1'b0;
      pp_at = -1; pp_n = 0; rel_n = 0;
      for (int j = 0; j < 10; j++) begin
         step();
         if (press_pulse) begin pp_n++; if (pp_at < 0) pp_at = j; end
         if (release_pulse) rel_n++;
      end
      check("re-press press_pulse edge", pp_at, 6);
      check("re-press press_pulse count", pp_n, 1);
      check("re-press no release_pulse", rel_n, 0);
      check("re-press press_count", press_count, 1);
      btn_n = 1'b1;
      repeat (12) step();

      // ---------------- 256 presses wrap the counter ----------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      pp_total = 0; rel_total = 0;
      for (int p = 0; p < 256; p++) begin
         btn_n = 1'b0;
         for (int j = 0; j < 10; j++) begin
            step();
            if (press_pulse) pp_total++;
            if (release_pulse) rel_total++;
         end
         btn_n = 1'b1;
         for (int j = 0; j < 12; j++) begin
            step();
            if (press_pulse) pp_total++;
            if (release_pulse) rel_total++;
         end
         if (p == 254) check("press_count after 255 presses", press_count, 255);
      end
      check("wrap press_count", press_count, 0);
      check("wrap press_pulse total", pp_total, 256);
      check("wrap release_pulse total", rel_total, 256);

      check("single pulse per cycle violations", multi_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_reader.md
# button_reader

Debounced pushbutton input reader for the iCEstick-class 12 MHz designs. It is the input-side counterpart to the LED-driving counter logic. It takes one raw, asynchronous, active-low button pin, synchronises and debounces it, and emits a clean level plus one-cycle press, release and long-press event pulses, along with a wrapping press counter. Top-level logic uses these outputs to drive LEDs or mode changes.

## Interface
- `DEBOUNCE_TICKS`, default 120000: consecutive stable samples required to accept a level change (10 ms at 12 MHz); must be ≥ 2.
- `LONG_TICKS`, default 12000000: cycles in the held state before the long-press event fires (1 s at 12 MHz); must be ≥ 2.
- `clk` input 1: sole clock.
- `rst` input 1: **synchronous, active-high reset**.
- `btn_n` input 1: raw button pin, active-low, asynchronous to `clk`.
- `pressed` output 1: debounced level, 1 while the button is accepted as held.
- `press_pulse` output 1: one-cycle pulse on an accepted press.
- `release_pulse` output 1: one-cycle pulse on an accepted release.
- `long_pulse` output 1: one-cycle pulse when a press has been held for `LONG_TICKS`.
- `press_count` output 8: count of accepted presses; wraps 255→0.

## Operation
- **Synchroniser:** two flops on `btn_n`, both reset to 1. `s` is the inverse of the second flop (1 = pressed).
- **States:** IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE. `dcnt` is the debounce counter, sized with $clog2(DEBOUNCE_TICKS). `lcnt` is the long counter, sized with $clog2(LONG_TICKS).
- **IDLE:** if `s`=1, go to DEB_PRESS and set `dcnt`=0.
- **DEB_PRESS:**
  - If `s`=0, return to IDLE with no event.
  - Otherwise, if `dcnt`==DEBOUNCE_TICKS-1, go to HELD: `pressed`←1, `press_pulse`←1, `press_count`←`press_count`+1, `lcnt`←0.
  - Otherwise, `dcnt`++.
- **HELD:**
  - If `s`=0, go to DEB_RELEASE with `dcnt`=0.
  - Otherwise, if `lcnt`==LONG_TICKS-1, go to LONG_HELD with `long_pulse`←1.
  - Otherwise, `lcnt`++.
- **LONG_HELD:** if `s`=0, go to DEB_RELEASE with `dcnt`=0. `lcnt` holds its value.
- **DEB_RELEASE:**
  - If `s`=1 (bounce), return to HELD if the long press has not fired, or to LONG_HELD if it has. A one-bit `long_done` flag records this. `lcnt` is not reset, so release bounce never retriggers or delays the long press.
  - If `dcnt`==DEBOUNCE_TICKS-1 with `s`=0, go to IDLE: `pressed`←0, `release_pulse`←1, `long_done`←0.
  - Otherwise, `dcnt`++.
- `pressed` stays 1 throughout DEB_RELEASE.
- All outputs are registered. Each pulse is high for exactly one cycle, and at most one pulse fires per cycle.

## Timing
- Edge 0 is the first `clk` edge at which `btn_n` is sampled low and stays low.
  - `s`=1 is seen by the FSM at edge 2, which enters DEB_PRESS.
  - `press_pulse`, `pressed` and the count increment become visible after edge DEBOUNCE_TICKS+2.
- Release latency is symmetric: `release_pulse` becomes visible after edge DEBOUNCE_TICKS+2, measured from the first low-sampled edge of `s`.
- `long_pulse` becomes visible LONG_TICKS edges after `press_pulse`, provided the button is held.
- A bounce shorter than DEBOUNCE_TICKS cycles produces no event and no level change.
- Reset values: all outputs 0, `press_count`=0, state IDLE, synchroniser flops 1, `long_done`=0, counters 0.
- Reset has priority over every transition.
- Reset while the button is held: after `rst` deasserts, the press is re-debounced and `press_pulse` fires again. No `release_pulse` is emitted for the aborted press.

## Configuration
- **`BUTTON_READER_LONG_PRESS_EN` defined:** long-press logic as above.
- **Not defined:**
  - LONG_HELD, `lcnt` and `long_done` are removed, and `LONG_TICKS` is ignored.
  - `long_pulse` is tied to 0.
  - HELD stays in HELD until `s`=0, and DEB_RELEASE bounce returns to HELD.

## Structure
- **Package `button_pkg`:** state enum `btn_state_t` (IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE), plus constants `CLK_HZ`=12000000 and `PRESS_COUNT_W`=8.
- **Sub-module `btn_sync`:** the two-flop synchroniser, with parameter reset value 1 and ports `clk`, `rst`, `d`, `q`. The FSM and counters stay in `button_reader`.

## Test plan
All scenarios use DEBOUNCE_TICKS=4 and LONG_TICKS=16.
- **Clean press:** `btn_n` goes 1→0 and is held 30 cycles → `press_pulse` for one cycle after edge 6, `pressed`=1, `press_count`=1.
- **Glitch:** `btn_n` low for 3 cycles, then high → no pulses, `pressed`=0, `press_count`=0.
- **Long press (macro on):** hold → `long_pulse` for one cycle, 16 cycles after `press_pulse`. Then release with a 2-cycle high-low bounce → exactly one `release_pulse` and no second `long_pulse`.
- **Wrap:** 256 clean presses → `press_count`=0 with 256 `press_pulse`s.
- **Reset mid-press:** `rst` held 1 cycle while held in HELD → outputs 0 the next cycle. The press is then re-accepted 6 cycles after `rst` deasserts, with `press_count`=1.
- **Macro off:** hold 40 cycles → `long_pulse` never asserts. The release produces `release_pulse` after DEBOUNCE_TICKS+2 edges.
